// File: rtl/mult_share_arb_pkg.sv
// Shared constants and types for the two-requester multiplier arbiter and its bench.
package mult_share_arb_pkg;

  localparam int unsigned MULT_LAT = 2;
  localparam int unsigned ID_W     = 1;

  localparam logic [ID_W-1:0] REQ0 = 1'b0;
  localparam logic [ID_W-1:0] REQ1 = 1'b1;

  // One stage of the response tag pipeline
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  function automatic logic [ID_W-1:0] onehot_to_id(input logic [1:0] grant);
    return grant[1] ? REQ1 : REQ0;
  endfunction

endpackage

// File: rtl/mult_share_arb_rr_arb_2.sv
// Two-input round-robin arbiter; last_grant advances only on an accepted transfer.
module rr_arb_2
  import mult_share_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic [ID_W-1:0] last_grant_q;
  logic [ID_W-1:0] last_grant_d;

  // Contention goes to whoever did not win last; a lone requester always wins
  always_comb begin
    grant        = valid;
    last_grant_d = last_grant_q;
    if (valid == 2'b11) begin
      grant = (last_grant_q == REQ0) ? 2'b10 : 2'b01;
    end
    if (advance) begin
      last_grant_d = onehot_to_id(grant);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant_q <= REQ1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Shares one registered NxN multiplier between two requesters with tagged,
// fixed-latency responses and per-requester saturating completion counters.
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid_0,
  input  logic [N-1:0]     req_a_0,
  input  logic [N-1:0]     req_b_0,
  output logic             req_ready_0,
  input  logic             req_valid_1,
  input  logic [N-1:0]     req_a_1,
  input  logic [N-1:0]     req_b_1,
  output logic             req_ready_1,
  output logic             mult_ea,
  output logic             mult_eb,
  output logic [N-1:0]     mult_a,
  output logic [N-1:0]     mult_b,
  input  logic [2*N-1:0]   mult_p,
  output logic             rsp_valid,
  output logic [ID_W-1:0]  rsp_id,
  output logic [2*N-1:0]   rsp_p,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0] valid_c;
  logic [1:0] grant_c;
  logic       issue_c;

  tag_t [MULT_LAT-1:0] tag_q;
  tag_t [MULT_LAT-1:0] tag_d;
  logic [CNT_W-1:0]    cnt_0_q, cnt_0_d;
  logic [CNT_W-1:0]    cnt_1_q, cnt_1_d;

  // Requests are masked while reset is held so no grant or load can escape
  assign valid_c = {req_valid_1, req_valid_0} & {2{reset_n}};
  assign issue_c = |grant_c;

  rr_arb_2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .valid   (valid_c),
    .advance (issue_c),
    .grant   (grant_c)
  );

  // Operand mux, handshake and response gating
  always_comb begin
    req_ready_0 = grant_c[0];
    req_ready_1 = grant_c[1];
    mult_ea     = issue_c;
    mult_eb     = issue_c;
    mult_a      = '0;
    mult_b      = '0;
    if (grant_c[0]) begin
      mult_a = req_a_0;
      mult_b = req_b_0;
    end else if (grant_c[1]) begin
      mult_a = req_a_1;
      mult_b = req_b_1;
    end

    rsp_valid = tag_q[MULT_LAT-1].vld & reset_n;
    rsp_id    = rsp_valid ? tag_q[MULT_LAT-1].id : REQ0;
    rsp_p     = rsp_valid ? mult_p : '0;

    busy = 1'b0;
    for (int i = 0; i < int'(MULT_LAT); i++) begin
      busy = busy | tag_q[i].vld;
    end
    busy = busy & reset_n;
  end

  // Tag pipeline shift and saturating counters
  always_comb begin
    tag_d[0].vld = issue_c;
    tag_d[0].id  = onehot_to_id(grant_c);
    for (int i = 1; i < int'(MULT_LAT); i++) begin
      tag_d[i] = tag_q[i-1];
    end

    cnt_0_d = cnt_0_q;
    cnt_1_d = cnt_1_q;
    if (rsp_valid && (rsp_id == REQ0) && (cnt_0_q != CNT_MAX)) begin
      cnt_0_d = cnt_0_q + CNT_W'(1);
    end
    if (rsp_valid && (rsp_id == REQ1) && (cnt_1_q != CNT_MAX)) begin
      cnt_1_d = cnt_1_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tag_q   <= '0;
      cnt_0_q <= '0;
      cnt_1_q <= '0;
    end else begin
      tag_q   <= tag_d;
      cnt_0_q <= cnt_0_d;
      cnt_1_q <= cnt_1_d;
    end
  end

  assign cnt_0 = cnt_0_q;
  assign cnt_1 = cnt_1_q;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench: mult_share_arb (plus a CNT_W=2 copy) driving a registered multiplier model.
module tb_mult_share_arb;
  import mult_share_arb_pkg::*;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid_0, req_valid_1;
  logic [N-1:0] req_a_0, req_b_0, req_a_1, req_b_1;

  logic           req_ready_0, req_ready_1, mult_ea, mult_eb, rsp_valid, busy;
  logic [N-1:0]   mult_a, mult_b;
  logic [2*N-1:0] mult_p, rsp_p;
  logic [ID_W-1:0] rsp_id;
  logic [15:0]    cnt_0, cnt_1;

  logic           s_ready_0, s_ready_1, s_ea, s_eb, s_rsp_valid, s_busy;
  logic [N-1:0]   s_mult_a, s_mult_b;
  logic [2*N-1:0] s_rsp_p;
  logic [ID_W-1:0] s_rsp_id;
  logic [1:0]     s_cnt_0, s_cnt_1;

  logic [N-1:0]   ma_q, mb_q;
  logic [2*N-1:0] mp_q;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_share_arb #(.N(N), .CNT_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_0(req_valid_0), .req_a_0(req_a_0), .req_b_0(req_b_0), .req_ready_0(req_ready_0),
    .req_valid_1(req_valid_1), .req_a_1(req_a_1), .req_b_1(req_b_1), .req_ready_1(req_ready_1),
    .mult_ea(mult_ea), .mult_eb(mult_eb), .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .cnt_0(cnt_0), .cnt_1(cnt_1), .busy(busy)
  );

  mult_share_arb #(.N(N), .CNT_W(2)) u_dut_sat (
    .clk(clk), .reset_n(reset_n),
    .req_valid_0(req_valid_0), .req_a_0(req_a_0), .req_b_0(req_b_0), .req_ready_0(s_ready_0),
    .req_valid_1(req_valid_1), .req_a_1(req_a_1), .req_b_1(req_b_1), .req_ready_1(s_ready_1),
    .mult_ea(s_ea), .mult_eb(s_eb), .mult_a(s_mult_a), .mult_b(s_mult_b), .mult_p(mult_p),
    .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id), .rsp_p(s_rsp_p),
    .cnt_0(s_cnt_0), .cnt_1(s_cnt_1), .busy(s_busy)
  );

  // Registered multiplier: operand registers load on enables, product registered once more
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ma_q <= '0;
      mb_q <= '0;
      mp_q <= '0;
    end else begin
      if (mult_ea) ma_q <= mult_a;
      if (mult_eb) mb_q <= mult_b;
      mp_q <= (2*N)'(ma_q) * (2*N)'(mb_q);
    end
  end
  assign mult_p = mp_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge, then let inputs settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_a_0 = '0; req_b_0 = '0; req_a_1 = '0; req_b_1 = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_in();
    tick(); tick();
    reset_n = 1'b1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [ID_W-1:0] id,
                         input logic [15:0] p);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'(v));
    chk({tag, "_id"},  32'(rsp_id),    32'(id));
    chk({tag, "_p"},   32'(rsp_p),     32'(p));
  endtask

  logic [15:0] exp_p [4];
  logic [15:0] exp_c;

  initial begin
    idle_in();
    reset_n = 1'b0;
    tick();

    // Reset state while a request is presented
    req_valid_0 = 1'b1; req_a_0 = 8'h55; req_b_0 = 8'h66;
    settle();
    chk("rst_ready0", 32'(req_ready_0), 0);
    chk("rst_ea",     32'(mult_ea), 0);
    chk("rst_mult_a", 32'(mult_a), 0);
    chk("rst_busy",   32'(busy), 0);
    chk_rsp("rst", 1'b0, REQ0, 16'h0);
    tick();
    chk("rst_cnt0", 32'(cnt_0), 0);
    idle_in();
    tick();
    reset_n = 1'b1;

    // Single request from R0
    req_valid_0 = 1'b1; req_a_0 = 8'h0C; req_b_0 = 8'h0A;
    settle();
    chk("single_ready0", 32'(req_ready_0), 1);
    chk("single_ea",     32'(mult_ea), 1);
    chk("single_eb",     32'(mult_eb), 1);
    chk("single_mult_a", 32'(mult_a), 32'h0C);
    chk("single_mult_b", 32'(mult_b), 32'h0A);
    tick(); idle_in(); settle();
    chk("single_t1_busy", 32'(busy), 1);
    chk("single_t1_vld",  32'(rsp_valid), 0);
    chk("single_t1_ea",   32'(mult_ea), 0);
    tick(); settle();
    chk_rsp("single_t2", 1'b1, REQ0, 16'h0078);
    tick(); settle();
    chk("single_cnt0", 32'(cnt_0), 1);
    chk("single_t3_vld", 32'(rsp_valid), 0);

    // Contention from reset: grants alternate starting with R0
    do_reset();
    exp_p[0] = 16'h000F; exp_p[1] = 16'hFE01; exp_p[2] = 16'h000F; exp_p[3] = 16'hFE01;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        req_valid_0 = 1'b1; req_a_0 = 8'h03; req_b_0 = 8'h05;
        req_valid_1 = 1'b1; req_a_1 = 8'hFF; req_b_1 = 8'hFF;
      end else begin
        idle_in();
      end
      settle();
      if (c < 4) begin
        chk($sformatf("cont%0d_ready0", c), 32'(req_ready_0), 32'(c % 2 == 0));
        chk($sformatf("cont%0d_ready1", c), 32'(req_ready_1), 32'(c % 2 == 1));
        chk($sformatf("cont%0d_mult_a", c), 32'(mult_a), (c % 2 == 0) ? 32'h03 : 32'hFF);
      end
      if (c >= 2) begin
        chk_rsp($sformatf("cont_rsp%0d", c - 2), 1'b1,
                ((c - 2) % 2 == 0) ? REQ0 : REQ1, exp_p[c-2]);
      end
      tick();
    end
    settle();
    chk("cont_cnt0", 32'(cnt_0), 2);
    chk("cont_cnt1", 32'(cnt_1), 2);

    // Idle gap: single R1 request, stale product must not leak onto rsp_p
    req_valid_1 = 1'b1; req_a_1 = 8'h02; req_b_1 = 8'h07;
    settle();
    chk("gap_ready1", 32'(req_ready_1), 1);
    tick(); idle_in(); settle();
    chk("gap_t1_busy", 32'(busy), 1);
    chk("gap_t1_vld",  32'(rsp_valid), 0);
    tick(); settle();
    chk_rsp("gap_t2", 1'b1, REQ1, 16'h000E);
    chk("gap_t2_busy", 32'(busy), 1);
    for (int c = 3; c < 6; c++) begin
      tick(); settle();
      chk_rsp($sformatf("gap_t%0d", c), 1'b0, REQ0, 16'h0);
      if (c == 3) chk("gap_t3_busy", 32'(busy), 0);
    end

    // Stall hold: make R0 the last winner, then R1 wins contention and R0 waits
    req_valid_0 = 1'b1; req_a_0 = 8'h01; req_b_0 = 8'h01;
    tick(); idle_in(); tick(); tick(); tick();
    req_valid_0 = 1'b1; req_a_0 = 8'h11; req_b_0 = 8'h02;
    req_valid_1 = 1'b1; req_a_1 = 8'h04; req_b_1 = 8'h05;
    settle();
    chk("stall_t0_ready0", 32'(req_ready_0), 0);
    chk("stall_t0_ready1", 32'(req_ready_1), 1);
    chk("stall_t0_mult_a", 32'(mult_a), 32'h04);
    tick();
    req_valid_1 = 1'b0;
    settle();
    chk("stall_t1_ready0", 32'(req_ready_0), 1);
    chk("stall_t1_mult_a", 32'(mult_a), 32'h11);
    tick(); idle_in(); settle();
    chk_rsp("stall_t2", 1'b1, REQ1, 16'h0014);
    tick(); settle();
    chk_rsp("stall_t3", 1'b1, REQ0, 16'h0022);

    // Reset mid-flight: the in-flight result is dropped
    tick(); tick();
    req_valid_0 = 1'b1; req_a_0 = 8'h09; req_b_0 = 8'h09;
    tick();
    reset_n = 1'b0; idle_in();
    settle();
    chk("mid_rst_vld",  32'(rsp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    tick();
    reset_n = 1'b1;
    req_valid_0 = 1'b1; req_a_0 = 8'h01; req_b_0 = 8'h02;
    req_valid_1 = 1'b1; req_a_1 = 8'h03; req_b_1 = 8'h04;
    settle();
    chk("mid_t2_vld",    32'(rsp_valid), 0);
    chk("mid_cnt0",      32'(cnt_0), 0);
    chk("mid_cnt1",      32'(cnt_1), 0);
    chk("mid_ready0",    32'(req_ready_0), 1);
    chk("mid_ready1",    32'(req_ready_1), 0);
    tick(); idle_in(); tick(); tick(); tick();

    // Saturation on the CNT_W=2 instance: five back-to-back R0 responses
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        req_valid_0 = 1'b1; req_a_0 = 8'(c + 1); req_b_0 = 8'h03;
      end else begin
        idle_in();
      end
      settle();
      if (c >= 3) begin
        exp_c = 16'((c - 2 > 3) ? 3 : c - 2);
        chk($sformatf("sat_c%0d_cnt0", c), 32'(s_cnt_0), 32'(exp_c));
        chk($sformatf("sat_c%0d_cnt1", c), 32'(s_cnt_1), 0);
        chk($sformatf("sat_c%0d_wide", c), 32'(cnt_0), 32'(c - 2));
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

endmodule
